// File: rtl/alu_arbiter.sv
// Two-requester arbiter that time-shares one 32-bit R-type ALU.
// Operands are registered on accept, evaluated in EXEC, and the result is held in RESP until the owner accepts it.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [31:0] req0_rs1_i,
  input  logic [31:0] req0_rs2_i,
  input  logic [31:0] req1_rs1_i,
  input  logic [31:0] req1_rs2_i,
  input  logic [3:0]  req0_op_i,
  input  logic [3:0]  req1_op_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        busy_o
);

  // state | meaning
  // IDLE  | waiting for a request; grant is presented on req_ready_o
  // EXEC  | ALU evaluates the registered operands; result captured at the end
  // RESP  | result held on rsp_data_o until the owner takes it
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] rs1_q, rs2_q, res_q;
  logic [3:0]  op_q;
  logic        owner_q, last_q;
  logic [1:0]  grant;
  logic        accept;
  logic        acc_sel;
  logic [31:0] alu_y;

  // op[2:0] = funct3, op[3] = funct7[5]
  function automatic logic [31:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
    logic [31:0] y;
    case (op[2:0])
      3'b000:  y = op[3] ? (a - b) : (a + b);
      3'b001:  y = a << b[4:0];
      3'b010:  y = {31'b0, ($signed(a) < $signed(b))};
      3'b011:  y = {31'b0, (a < b)};
      3'b100:  y = a ^ b;
      3'b101:  y = op[3] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  y = a | b;
      default: y = a & b;
    endcase
    return y;
  endfunction

  assign alu_y = alu_eval(rs1_q, rs2_q, op_q);

  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE && !rst_i) begin
      case (req_valid_i)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (RR_EN && !last_q) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign accept  = |(req_valid_i & grant);
  assign acc_sel = grant[1];

  always_comb begin
    state_d     = state_q;
    req_ready_o = grant;
    rsp_valid_o = 2'b00;
    rsp_data_o  = res_q;
    busy_o      = (state_q != IDLE);
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid_o = owner_q ? 2'b10 : 2'b01;
        if (rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rs1_q   <= 32'd0;
      rs2_q   <= 32'd0;
      res_q   <= 32'd0;
      op_q    <= 4'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        rs1_q   <= acc_sel ? req1_rs1_i : req0_rs1_i;
        rs2_q   <= acc_sel ? req1_rs2_i : req0_rs2_i;
        op_q    <= acc_sel ? req1_op_i  : req0_op_i;
        owner_q <= acc_sel;
        last_q  <= acc_sel;
      end
      if (state_q == EXEC) res_q <= alu_y;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority instance share all inputs.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] r0_rs1, r0_rs2, r1_rs1, r1_rs2;
  logic [3:0]  r0_op, r1_op;
  logic [1:0]  rsp_ready;

  logic [1:0]  rr_req_ready, rr_rsp_valid, fp_req_ready, fp_rsp_valid;
  logic [31:0] rr_rsp_data, fp_rsp_data;
  logic        rr_busy, fp_busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rr_req_ready),
    .req0_rs1_i(r0_rs1), .req0_rs2_i(r0_rs2), .req1_rs1_i(r1_rs1), .req1_rs2_i(r1_rs2),
    .req0_op_i(r0_op), .req1_op_i(r1_op), .rsp_valid_o(rr_rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rr_rsp_data), .busy_o(rr_busy));

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(fp_req_ready),
    .req0_rs1_i(r0_rs1), .req0_rs2_i(r0_rs2), .req1_rs1_i(r1_rs1), .req1_rs2_i(r1_rs2),
    .req0_op_i(r0_op), .req1_op_i(r1_op), .rsp_valid_o(fp_rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(fp_rsp_data), .busy_o(fp_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rr_ready"}, 32'(rr_req_ready), 32'd0);
    chk({tag, " rr_rvalid"}, 32'(rr_rsp_valid), 32'd0);
    chk({tag, " rr_data"}, rr_rsp_data, 32'd0);
    chk({tag, " rr_busy"}, 32'(rr_busy), 32'd0);
    chk({tag, " fp_rvalid"}, 32'(fp_rsp_valid), 32'd0);
    chk({tag, " fp_busy"}, 32'(fp_busy), 32'd0);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  // One single-requester op through both instances with rsp_ready already high.
  task automatic single_op(input string tag, input int k, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op,
                           input logic [31:0] exp);
    logic [1:0] kv;
    kv = (k == 1) ? 2'b10 : 2'b01;
    if (k == 1) begin r1_rs1 = a; r1_rs2 = b; r1_op = op; end
    else begin r0_rs1 = a; r0_rs2 = b; r0_op = op; end
    req_valid = kv;
    rsp_ready = kv;
    #1;
    chk({tag, " ready same cycle"}, 32'(rr_req_ready), 32'(kv));
    chk({tag, " fp ready"}, 32'(fp_req_ready), 32'(kv));
    tick();
    req_valid = 2'b00;
    #1;
    chk({tag, " exec busy"}, 32'(rr_busy), 32'd1);
    chk({tag, " exec no rsp"}, 32'(rr_rsp_valid), 32'd0);
    tick();
    #1;
    chk({tag, " rsp_valid"}, 32'(rr_rsp_valid), 32'(kv));
    chk({tag, " rsp_data"}, rr_rsp_data, exp);
    chk({tag, " fp rsp_data"}, fp_rsp_data, exp);
    tick();
    #1;
    chk({tag, " back idle"}, 32'(rr_busy), 32'd0);
    chk({tag, " rsp dropped"}, 32'(rr_rsp_valid), 32'd0);
    rsp_ready = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    r0_rs1 = '0; r0_rs2 = '0; r1_rs1 = '0; r1_rs2 = '0;
    r0_op = '0; r1_op = '0;
    tick();
    tick();
    #1;
    chk("reset ready while rst", 32'(rr_req_ready), 32'd0);
    chk("reset fp ready while rst", 32'(fp_req_ready), 32'd0);
    chk_all_zero("reset");

    // Basic add and sub wrap-around
    tick();
    rst = 1'b0;
    single_op("add r0", 0, 32'd5, 32'd7, 4'b0000, 32'd12);
    single_op("sub r1", 1, 32'd0, 32'd1, 4'b1000, 32'hFFFF_FFFF);

    // Tie: both valid continuously after reset; rr grants 0,1,0, fp always 0
    do_reset();
    r0_rs1 = 32'hF0F0_F0F0; r0_rs2 = 32'hFF00_FF00; r0_op = 4'b0111;
    r1_rs1 = 32'h0000_0001; r1_rs2 = 32'h0000_0002; r1_op = 4'b0110;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      logic [1:0] g;
      logic [31:0] d;
      g = (i == 1) ? 2'b10 : 2'b01;
      d = (i == 1) ? 32'h0000_0003 : 32'hF000_F000;
      #1;
      chk($sformatf("tie rr grant %0d", i), 32'(rr_req_ready), 32'(g));
      chk($sformatf("tie fp grant %0d", i), 32'(fp_req_ready), 32'd1);
      tick();
      #1;
      chk($sformatf("tie fp r1 ready exec %0d", i), 32'(fp_req_ready[1]), 32'd0);
      tick();
      #1;
      chk($sformatf("tie rr rvalid %0d", i), 32'(rr_rsp_valid), 32'(g));
      chk($sformatf("tie rr data %0d", i), rr_rsp_data, d);
      chk($sformatf("tie fp rvalid %0d", i), 32'(fp_rsp_valid), 32'd1);
      chk($sformatf("tie fp data %0d", i), fp_rsp_data, 32'hF000_F000);
      tick();
    end

    // Backpressure on sra while requester 1 waits
    do_reset();
    r0_rs1 = 32'h8000_0000; r0_rs2 = 32'd4; r0_op = 4'b1101;
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    tick();
    req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp rvalid %0d", i), 32'(rr_rsp_valid), 32'd1);
      chk($sformatf("bp data %0d", i), rr_rsp_data, 32'hF800_0000);
      chk($sformatf("bp rr ready %0d", i), 32'(rr_req_ready), 32'd0);
      chk($sformatf("bp fp ready %0d", i), 32'(fp_req_ready), 32'd0);
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    chk("bp non-owner ready ignored", 32'(rr_rsp_valid), 32'd1);
    tick();
    #1;
    chk("bp still held", 32'(rr_busy), 32'd1);
    rsp_ready = 2'b01;
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;
    chk("bp idle after ready", 32'(rr_busy), 32'd0);
    chk("bp rvalid low", 32'(rr_rsp_valid), 32'd0);

    // Reset during EXEC
    do_reset();
    r0_rs1 = 32'd1; r0_rs2 = 32'd1; r0_op = 4'b0000;
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    tick();
    req_valid = 2'b00;
    #1;
    chk("rst exec busy", 32'(rr_busy), 32'd1);
    rst = 1'b1;
    tick();
    #1;
    chk_all_zero("after rst exec");
    rst = 1'b0;
    tick();
    #1;
    chk("rst exec no pulse", 32'(rr_rsp_valid), 32'd0);
    chk("rst exec idle", 32'(rr_busy), 32'd0);

    // Reset during RESP
    r1_rs1 = 32'd3; r1_rs2 = 32'd4; r1_op = 4'b0000;
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    tick();
    #1;
    chk("rst resp rvalid before", 32'(rr_rsp_valid), 32'd2);
    chk("rst resp data before", rr_rsp_data, 32'd7);
    rst = 1'b1;
    tick();
    #1;
    chk_all_zero("after rst resp");
    rst = 1'b0;
    rsp_ready = 2'b11;
    tick();
    #1;
    chk("rst resp no pulse", 32'(rr_rsp_valid), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("post-reset tie rr grants 0", 32'(rr_req_ready), 32'd1);
    chk("post-reset tie fp grants 0", 32'(fp_req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer that shares one 32-bit combinational `ALU` instance between the pipeline execute stage (requester 0) and a secondary client such as the address/branch unit (requester 1). Each requester gets a valid/ready request channel and a valid/ready response channel. The block registers the granted operands, evaluates them through the `ALU` in a dedicated cycle, and holds the result until the owning requester accepts it. Only one operation is in flight at a time.

## Interface
- `RR_EN`, default 1: arbitration mode. 1 = round-robin; 0 = fixed priority, requester 0 wins.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `req_valid_i`  in  2  bit k = requester k presents an operation.
- `req_ready_o`  out  2  bit k = the block accepts requester k's operation this cycle.
- `req0_rs1_i`, `req0_rs2_i`  in  32 each  requester 0 operands.
- `req1_rs1_i`, `req1_rs2_i`  in  32 each  requester 1 operands.
- `req0_op_i`, `req1_op_i`  in  4 each  ALU opcode. Bits [2:0] = funct3, bit [3] = funct7[5].
- `rsp_valid_o`  out  2  bit k = result for requester k is available.
- `rsp_ready_i`  in  2  bit k = requester k takes the result.
- `rsp_data_o`  out  32  result, shared by both requesters; qualified by `rsp_valid_o`.
- `busy_o`  out  1  high in every state other than IDLE.

## Operation
- **FSM states:** IDLE, EXEC, RESP. Reset state is IDLE.
- **Grant (IDLE only, combinational):**
  - If exactly one `req_valid_i` bit is set, that requester is granted.
  - If both bits are set and `RR_EN`=1, the requester not recorded in `last_q` is granted.
  - If both bits are set and `RR_EN`=0, requester 0 is granted.
- **`req_ready_o`:** equals the grant vector in IDLE and is 2'b00 in every other state. At most one bit is ever high.
- **Accept (IDLE, valid&ready on requester k):**
  - Latch rs1, rs2 and op into `rs1_q`, `rs2_q`, `op_q`.
  - Set `owner_q` = k and `last_q` = k.
  - Go to EXEC.
- **EXEC:**
  - `ALU` inputs are driven only from `rs1_q`, `rs2_q`, `op_q`.
  - `ALU` output is captured into `res_q`.
  - Go to RESP unconditionally.
- **RESP:**
  - `rsp_valid_o[owner_q]` = 1; the other bit is 0.
  - `rsp_data_o` = `res_q`.
  - On `rsp_ready_i[owner_q]`, go to IDLE.
  - `rsp_ready_i` of the non-owner is ignored.
- **Requester obligation:** operands and op stay stable while valid is high and ready is low. The block does not check this.
- **Response stability:** `rsp_data_o` and `rsp_valid_o` stay stable until the handshake completes, with no timeout.
- **`rsp_data_o` outside RESP:** equals `res_q`, but is not qualified.
- **`ALU` behaviour:** unchanged, including 32-bit wrap-around on add and sub with no overflow flag. Opcodes outside the ten R-type functions produce whatever the `ALU` produces, with no special handling.
- **Reset values:**
  - State = IDLE.
  - `rs1_q`, `rs2_q`, `res_q` = 0; `op_q` = 0; `owner_q` = 0.
  - `last_q` = 1, so requester 0 wins the first tie.
  - Outputs `req_ready_o` = 0 while `rst_i` is high, `rsp_valid_o` = 0, `rsp_data_o` = 0, `busy_o` = 0.
- **Reset mid-operation:** `rst_i` in EXEC or RESP aborts the operation.
  - No response is ever issued for the aborted operation.
  - Registers return to their reset values on that edge.
- **Requester dropping valid:** a requester that deasserts valid before acceptance is simply not granted. Nothing is latched for it.

## Timing
- Accept at edge N (IDLE, valid&ready).
- EXEC during cycle N..N+1; `res_q` is written at edge N+1.
- `rsp_valid_o` is high from cycle N+1 onward.
- If `rsp_ready_i` is already high, the response completes at edge N+2.
- The next accept is possible at edge N+3, in IDLE. Peak throughput is one operation per 3 cycles.
- Each stall cycle on `rsp_ready_i` delays the return to IDLE by one cycle.
- Grant depends only on `req_valid_i` and `last_q`, both of which are registered or external. There is no combinational path from `rsp_ready_i` to `req_ready_o`.
- `ALU` delay sits only in EXEC, between the operand registers and `res_q`: one full cycle.

## Test plan
- **Basic add, requester 0 only:** rs1=5, rs2=7, op=4'b0000.
  - Required: ready in the same cycle.
  - Required: `rsp_valid_o`=2'b01 two cycles after accept, `rsp_data_o`=32'd12.
- **Sub wrap, requester 1 only:** rs1=0, rs2=1, op=4'b1000.
  - Required: `rsp_valid_o`=2'b10 with `rsp_data_o`=32'hFFFF_FFFF.
- **Tie with `RR_EN`=1, both valid continuously after reset, req0 = and 0xF0F0_F0F0 & 0xFF00_FF00:**
  - Required: grant order 0, 1, 0.
  - Required: req0 results = 32'hF000_F000.
- **Tie with `RR_EN`=0, both valid continuously:**
  - Required: requester 0 is granted on every accept.
  - Required: requester 1 `req_ready_o` never rises while req0 stays valid.
- **Backpressure, sra:** rs1=32'h8000_0000, rs2=4, op=4'b1101; hold `rsp_ready_i`=0 for 5 cycles.
  - Required: `rsp_valid_o` and `rsp_data_o`=32'hF800_0000 stable throughout.
  - Required: `req_ready_o`=0 throughout.
  - Required: IDLE one cycle after ready rises.
- **Reset in EXEC, then in RESP:**
  - Required: no `rsp_valid_o` pulse for the aborted operation.
  - Required: all outputs 0 in the cycle after the reset edge.
  - Required: the next tie grants requester 0.
